// File: rtl/core_pkg.sv
// Core-wide types shared by every pipeline block.
package core_pkg;

  localparam int XLEN = 64;

  typedef logic [XLEN-1:0] xlen_t;

endpackage

// File: rtl/csr_regfile_pkg.sv
// Shared RV machine-mode CSR definitions: addresses, mstatus layout, misa encoding.
package csr_regfile_pkg;

  import core_pkg::*;

  typedef logic [11:0] csr_addr_t;

  localparam csr_addr_t CSR_MSTATUS  = 12'h300;
  localparam csr_addr_t CSR_MISA     = 12'h301;
  localparam csr_addr_t CSR_MTVEC    = 12'h305;
  localparam csr_addr_t CSR_MSCRATCH = 12'h340;
  localparam csr_addr_t CSR_MEPC     = 12'h341;
  localparam csr_addr_t CSR_MCAUSE   = 12'h342;
  localparam csr_addr_t CSR_MTVAL    = 12'h343;
  localparam csr_addr_t CSR_MHARTID  = 12'hF14;
  localparam csr_addr_t CSR_MCYCLE   = 12'hB00;
  localparam csr_addr_t CSR_MINSTRET = 12'hB02;
  localparam csr_addr_t CSR_CYCLE    = 12'hC00;
  localparam csr_addr_t CSR_INSTRET  = 12'hC02;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // MXL=2 (64-bit) in the top two bits, extensions I (bit 8) and M (bit 12)
  localparam xlen_t MISA_RV64IM = {2'b10, {(XLEN-28){1'b0}}, 26'h000_1100};

  // Machine-only hart: MPP is hardwired to M, everything but MIE/MPIE reads 0
  function automatic xlen_t mstatus_pack(input logic mie, input logic mpie);
    xlen_t v;
    v = '0;
    v[MSTATUS_MIE] = mie;
    v[MSTATUS_MPIE] = mpie;
    v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return v;
  endfunction

endpackage

// File: rtl/csr_if.sv
// CSR access bus between the execute stage and the CSR file.
interface csr_if;

  import core_pkg::*;
  import csr_regfile_pkg::*;

  csr_addr_t raddr;
  xlen_t     rdata;
  csr_addr_t waddr;
  xlen_t     wdata;
  logic      wvalid;

  modport slave  (input raddr, waddr, wdata, wvalid, output rdata);
  modport master (output raddr, waddr, wdata, wvalid, input rdata);

endinterface

// File: rtl/csr_counter.sv
// 64-bit free-running counter with synchronous load that overrides the increment.
module csr_counter (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inc_en,
  input  logic        load_en,
  input  logic [63:0] load_val,
  output logic [63:0] count
);

  logic [63:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_reg <= '0;
    end else if (load_en) begin
      count_reg <= load_val;
    end else if (inc_en) begin
      count_reg <= count_reg + 64'd1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR file with trap/mret sequencing.
// Define CSR_PERF_CNT_EN to include the mcycle/minstret counters and their user aliases.
module csr_regfile
  import core_pkg::*;
  import csr_regfile_pkg::*;
#(
  parameter xlen_t HARTID   = '0,
  parameter xlen_t MISA_VAL = MISA_RV64IM
) (
  input  logic            clk,
  input  logic            rstn,
  csr_if.slave            csr_io,
  input  logic            instret_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_tval_i,
  input  logic            mret_valid_i,
  output logic [XLEN-1:0] trap_vec_o,
  output logic [XLEN-1:0] mepc_o
);

  logic            mie_reg, mie_next;
  logic            mpie_reg, mpie_next;
  logic [XLEN-1:2] mtvec_reg, mtvec_next;
  logic [XLEN-1:2] mepc_reg, mepc_next;
  xlen_t           mscratch_reg, mscratch_next;
  xlen_t           mcause_reg, mcause_next;
  xlen_t           mtval_reg, mtval_next;

  logic wr_mstatus, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mtval;
  logic unused_bits;

  assign wr_mstatus  = csr_io.wvalid && (csr_io.waddr == CSR_MSTATUS);
  assign wr_mtvec    = csr_io.wvalid && (csr_io.waddr == CSR_MTVEC);
  assign wr_mscratch = csr_io.wvalid && (csr_io.waddr == CSR_MSCRATCH);
  assign wr_mepc     = csr_io.wvalid && (csr_io.waddr == CSR_MEPC);
  assign wr_mcause   = csr_io.wvalid && (csr_io.waddr == CSR_MCAUSE);
  assign wr_mtval    = csr_io.wvalid && (csr_io.waddr == CSR_MTVAL);

  always_comb begin
    mie_next      = mie_reg;
    mpie_next     = mpie_reg;
    mtvec_next    = mtvec_reg;
    mepc_next     = mepc_reg;
    mscratch_next = mscratch_reg;
    mcause_next   = mcause_reg;
    mtval_next    = mtval_reg;

    if (wr_mtvec)    mtvec_next    = csr_io.wdata[XLEN-1:2];
    if (wr_mscratch) mscratch_next = csr_io.wdata;

    // Trap beats mret; either event locks out software writes to the trap CSRs
    if (trap_valid_i) begin
      mepc_next   = trap_pc_i[XLEN-1:2];
      mcause_next = trap_cause_i;
      mtval_next  = trap_tval_i;
      mpie_next   = mie_reg;
      mie_next    = 1'b0;
    end else if (mret_valid_i) begin
      mie_next  = mpie_reg;
      mpie_next = 1'b1;
    end else begin
      if (wr_mstatus) begin
        mie_next  = csr_io.wdata[MSTATUS_MIE];
        mpie_next = csr_io.wdata[MSTATUS_MPIE];
      end
      if (wr_mepc)   mepc_next   = csr_io.wdata[XLEN-1:2];
      if (wr_mcause) mcause_next = csr_io.wdata;
      if (wr_mtval)  mtval_next  = csr_io.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mie_reg      <= 1'b0;
      mpie_reg     <= 1'b0;
      mtvec_reg    <= '0;
      mepc_reg     <= '0;
      mscratch_reg <= '0;
      mcause_reg   <= '0;
      mtval_reg    <= '0;
    end else begin
      mie_reg      <= mie_next;
      mpie_reg     <= mpie_next;
      mtvec_reg    <= mtvec_next;
      mepc_reg     <= mepc_next;
      mscratch_reg <= mscratch_next;
      mcause_reg   <= mcause_next;
      mtval_reg    <= mtval_next;
    end
  end

`ifdef CSR_PERF_CNT_EN
  // Index 0 is mcycle, index 1 is minstret
  logic [1:0]  cnt_inc;
  logic [1:0]  cnt_load;
  logic [63:0] cnt_val [2];

  assign cnt_inc  = {instret_i, 1'b1};
  assign cnt_load = {csr_io.wvalid && (csr_io.waddr == CSR_MINSTRET),
                     csr_io.wvalid && (csr_io.waddr == CSR_MCYCLE)};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    csr_counter u_cnt (
      .clk      (clk),
      .rstn     (rstn),
      .inc_en   (cnt_inc[gi]),
      .load_en  (cnt_load[gi]),
      .load_val (csr_io.wdata),
      .count    (cnt_val[gi])
    );
  end

  assign unused_bits = ^trap_pc_i[1:0];
`else
  assign unused_bits = ^{trap_pc_i[1:0], instret_i};
`endif

  always_comb begin
    csr_io.rdata = '0;
    case (csr_io.raddr)
      CSR_MSTATUS:  csr_io.rdata = mstatus_pack(mie_reg, mpie_reg);
      CSR_MISA:     csr_io.rdata = MISA_VAL;
      CSR_MTVEC:    csr_io.rdata = {mtvec_reg, 2'b00};
      CSR_MSCRATCH: csr_io.rdata = mscratch_reg;
      CSR_MEPC:     csr_io.rdata = {mepc_reg, 2'b00};
      CSR_MCAUSE:   csr_io.rdata = mcause_reg;
      CSR_MTVAL:    csr_io.rdata = mtval_reg;
      CSR_MHARTID:  csr_io.rdata = HARTID;
`ifdef CSR_PERF_CNT_EN
      CSR_MCYCLE, CSR_CYCLE:     csr_io.rdata = cnt_val[0];
      CSR_MINSTRET, CSR_INSTRET: csr_io.rdata = cnt_val[1];
`endif
      default:      csr_io.rdata = '0;
    endcase
  end

  assign trap_vec_o = {mtvec_reg, 2'b00};
  assign mepc_o     = {mepc_reg, 2'b00};

endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile; counter checks follow CSR_PERF_CNT_EN.
module tb_csr_regfile;

  import core_pkg::*;
  import csr_regfile_pkg::*;

  logic        clk;
  logic        rstn;
  logic        instret_i;
  logic        trap_valid_i;
  logic [63:0] trap_pc_i;
  logic [63:0] trap_cause_i;
  logic [63:0] trap_tval_i;
  logic        mret_valid_i;
  logic [63:0] trap_vec_o;
  logic [63:0] mepc_o;

  int checks = 0;
  int failures = 0;

  csr_if csr_bus ();

  csr_regfile #(
    .HARTID (64'd3)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .csr_io       (csr_bus),
    .instret_i    (instret_i),
    .trap_valid_i (trap_valid_i),
    .trap_pc_i    (trap_pc_i),
    .trap_cause_i (trap_cause_i),
    .trap_tval_i  (trap_tval_i),
    .mret_valid_i (mret_valid_i),
    .trap_vec_o   (trap_vec_o),
    .mepc_o       (mepc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("check %s obs=0x%0h", tag, obs);
    end else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [63:0] exp);
    csr_bus.raddr = a;
    #1;
    check(tag, csr_bus.rdata, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    csr_bus.wvalid = 1'b1;
    csr_bus.waddr  = a;
    csr_bus.wdata  = d;
  endtask

  task automatic idle();
    csr_bus.wvalid = 1'b0;
    trap_valid_i   = 1'b0;
    mret_valid_i   = 1'b0;
    instret_i      = 1'b0;
  endtask

  task automatic trap(input logic [63:0] pc, input logic [63:0] cause, input logic [63:0] tval);
    trap_valid_i = 1'b1;
    trap_pc_i    = pc;
    trap_cause_i = cause;
    trap_tval_i  = tval;
  endtask

  initial begin
    rstn          = 1'b0;
    csr_bus.raddr = '0;
    csr_bus.waddr = '0;
    csr_bus.wdata = '0;
    idle();
    trap_pc_i     = '0;
    trap_cause_i  = '0;
    trap_tval_i   = '0;

    // Write held during reset must be dropped
    wr(CSR_MSCRATCH, 64'h1234);
    repeat (3) tick();
    rstn = 1'b1;
    idle();
    check("rst_trap_vec", trap_vec_o, 64'h0);
    check("rst_mepc_o", mepc_o, 64'h0);
    rd("rst_mscratch", CSR_MSCRATCH, 64'h0);
    rd("rst_mstatus", CSR_MSTATUS, 64'h1800);
    rd("mhartid", CSR_MHARTID, 64'd3);
    rd("unimpl_7c0", 12'h7C0, 64'h0);
    rd("misa", CSR_MISA, 64'h8000_0000_0000_1100);
    tick();

    // mtvec: low bits forced to zero, read sees old value in the write cycle
    wr(CSR_MTVEC, 64'h8000_0003);
    rd("mtvec_preupd", CSR_MTVEC, 64'h0);
    tick();
    idle();
    rd("mtvec", CSR_MTVEC, 64'h8000_0000);
    check("trap_vec", trap_vec_o, 64'h8000_0000);

    wr(CSR_MSTATUS, '1);
    tick();
    idle();
    rd("mstatus_ones", CSR_MSTATUS, 64'h1888);
    wr(CSR_MSTATUS, 64'h8);
    tick();
    idle();
    rd("mstatus_mie", CSR_MSTATUS, 64'h1808);

    wr(CSR_MEPC, 64'h57);
    tick();
    idle();
    rd("mepc_align", CSR_MEPC, 64'h54);
    check("mepc_o_align", mepc_o, 64'h54);
    wr(CSR_MSCRATCH, 64'hA5A5_0000_FFFF_0003);
    tick();
    idle();
    rd("mscratch", CSR_MSCRATCH, 64'hA5A5_0000_FFFF_0003);

    // Trap with a concurrent mepc write: trap wins
    trap(64'h1004, 64'd2, 64'hDEAD);
    wr(CSR_MEPC, 64'h55);
    rd("mepc_preupd", CSR_MEPC, 64'h54);
    tick();
    idle();
    rd("trap_mepc", CSR_MEPC, 64'h1004);
    rd("trap_mcause", CSR_MCAUSE, 64'd2);
    rd("trap_mtval", CSR_MTVAL, 64'hDEAD);
    rd("trap_mstatus", CSR_MSTATUS, 64'h1880);
    check("trap_mepc_o", mepc_o, 64'h1004);

    mret_valid_i = 1'b1;
    tick();
    idle();
    rd("mret_mstatus", CSR_MSTATUS, 64'h1888);

    // Trap alongside a write to an unrelated CSR: both take effect
    trap(64'h2000, 64'hB, 64'h0);
    wr(CSR_MSCRATCH, 64'h77);
    tick();
    idle();
    rd("trapwr_mscratch", CSR_MSCRATCH, 64'h77);
    rd("trapwr_mepc", CSR_MEPC, 64'h2000);
    rd("trapwr_mcause", CSR_MCAUSE, 64'hB);
    rd("trapwr_mstatus", CSR_MSTATUS, 64'h1880);

    // MIE=0, MPIE=1: trap gives 0x1800, mret would give 0x1888
    trap(64'h3000, 64'd5, 64'h9);
    mret_valid_i = 1'b1;
    tick();
    idle();
    rd("trapmret_mstatus", CSR_MSTATUS, 64'h1800);
    rd("trapmret_mepc", CSR_MEPC, 64'h3000);
    rd("trapmret_mcause", CSR_MCAUSE, 64'd5);

    // mret beats a software mstatus write
    mret_valid_i = 1'b1;
    wr(CSR_MSTATUS, 64'h8);
    tick();
    idle();
    rd("mretwr_mstatus", CSR_MSTATUS, 64'h1880);

    wr(CSR_MISA, 64'h0);
    tick();
    wr(CSR_MHARTID, 64'h0);
    tick();
    wr(12'h7C0, 64'hFF);
    tick();
    idle();
    rd("ro_misa", CSR_MISA, 64'h8000_0000_0000_1100);
    rd("ro_mhartid", CSR_MHARTID, 64'd3);
    rd("ro_unimpl", 12'h7C0, 64'h0);

`ifdef CSR_PERF_CNT_EN
    wr(CSR_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    idle();
    rd("mcycle_fe", CSR_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    rd("cycle_ff", CSR_CYCLE, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    rd("mcycle_wrap", CSR_MCYCLE, 64'h0);

    wr(CSR_MINSTRET, 64'h0);
    tick();
    idle();
    instret_i = 1'b1;
    repeat (5) tick();
    instret_i = 1'b0;
    rd("minstret_5", CSR_MINSTRET, 64'd5);
    rd("instret_5", CSR_INSTRET, 64'd5);

    // Load suppresses the same-cycle increment
    instret_i = 1'b1;
    wr(CSR_MINSTRET, 64'd100);
    tick();
    idle();
    rd("minstret_load", CSR_MINSTRET, 64'd100);

    wr(CSR_MCYCLE, 64'd1000);
    tick();
    wr(CSR_CYCLE, 64'd7);
    tick();
    idle();
    rd("cycle_ro", CSR_CYCLE, 64'd1001);
    rd("mcycle_ro", CSR_MCYCLE, 64'd1001);
`else
    wr(CSR_MCYCLE, 64'd5);
    tick();
    idle();
    repeat (100) tick();
    rd("nocnt_mcycle", CSR_MCYCLE, 64'h0);
    rd("nocnt_minstret", CSR_MINSTRET, 64'h0);
    rd("nocnt_cycle", CSR_CYCLE, 64'h0);
    rd("nocnt_instret", CSR_INSTRET, 64'h0);
`endif

    // Reset overrides a simultaneous trap, mret, write and increment
    rstn = 1'b0;
    trap(64'h4000, 64'd7, 64'h1);
    mret_valid_i = 1'b1;
    instret_i    = 1'b1;
    wr(CSR_MTVEC, 64'h100);
    tick();
    check("rstov_trap_vec", trap_vec_o, 64'h0);
    check("rstov_mepc_o", mepc_o, 64'h0);
    rd("rstov_mstatus", CSR_MSTATUS, 64'h1800);
    rd("rstov_mcause", CSR_MCAUSE, 64'h0);
`ifdef CSR_PERF_CNT_EN
    rd("rstov_mcycle", CSR_MCYCLE, 64'h0);
    rd("rstov_minstret", CSR_MINSTRET, 64'h0);
`endif
    rstn = 1'b1;
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
